// File: rtl/mem_sequencer.sv
// mem_sequencer: arbitrates the fetch and data requesters onto the shared
// 16-bit memory, sequences the read/write/push strobe phases and owns the
// drive enable of the bidirectional data bus.
module mem_sequencer #(
    parameter int unsigned STROBE_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_req,
    input  logic [15:0] if_addr,
    output logic        if_done,
    output logic [15:0] if_rdata,
    input  logic        dp_req,
    input  logic        dp_we,
    input  logic [15:0] dp_addr,
    input  logic [15:0] dp_wdata,
    output logic        dp_done,
    output logic [15:0] dp_rdata,
    output logic        d_read,
    output logic        d_write,
    output logic        d_push,
    output logic        i_read,
    output logic        i_push,
    output logic [15:0] d_addr,
    output logic [15:0] i_addr,
    inout  logic [15:0] d_bus
);

    typedef enum logic [2:0] {
        IDLE,
        DWR,
        DRD,
        DPUSH,
        IRD,
        IPUSH,
        DONE
    } state_e;

    localparam logic [1:0] CNT_LAST = 2'(STROBE_CYCLES - 1);

    state_e      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        last_data_q, last_data_d;   // 1: data port was granted last
    logic        grant_data, grant_fetch, phase_end;
    logic [15:0] d_addr_q, i_addr_q, wdata_q, if_rdata_q, dp_rdata_q;
    logic        d_read_q, d_write_q, d_push_q, i_read_q, i_push_q;
    logic        if_done_q, dp_done_q;

    // Arbitration, phase counting and next-state selection
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        last_data_d = last_data_q;
        grant_data  = 1'b0;
        grant_fetch = 1'b0;
        phase_end   = (cnt_q == CNT_LAST);
        case (state_q)
            IDLE: begin
                // On a tie the requester not granted last wins
                if (dp_req && (!if_req || !last_data_q)) begin
                    grant_data  = 1'b1;
                    last_data_d = 1'b1;
                    state_d     = dp_we ? DWR : DRD;
                    cnt_d       = '0;
                end else if (if_req) begin
                    grant_fetch = 1'b1;
                    last_data_d = 1'b0;
                    state_d     = IRD;
                    cnt_d       = '0;
                end
            end
            DWR, DRD, DPUSH, IRD, IPUSH: begin
                cnt_d = phase_end ? '0 : cnt_q + 2'd1;
                if (phase_end) begin
                    case (state_q)
                        DRD:     state_d = DPUSH;
                        IRD:     state_d = IPUSH;
                        default: state_d = DONE;
                    endcase
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State, captured transaction fields, registered strobes and read capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            last_data_q <= 1'b0;
            d_addr_q    <= '0;
            i_addr_q    <= '0;
            wdata_q     <= '0;
            if_rdata_q  <= '0;
            dp_rdata_q  <= '0;
            d_read_q    <= 1'b0;
            d_write_q   <= 1'b0;
            d_push_q    <= 1'b0;
            i_read_q    <= 1'b0;
            i_push_q    <= 1'b0;
            if_done_q   <= 1'b0;
            dp_done_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            last_data_q <= last_data_d;
            if (grant_data) begin
                d_addr_q <= dp_addr;
                wdata_q  <= dp_wdata;
            end
            if (grant_fetch) begin
                i_addr_q <= if_addr;
            end
            // Strobes are decoded from the next state so they are true flops
            d_read_q  <= (state_d == DRD);
            d_write_q <= (state_d == DWR);
            d_push_q  <= (state_d == DPUSH);
            i_read_q  <= (state_d == IRD);
            i_push_q  <= (state_d == IPUSH);
            dp_done_q <= (state_d == DONE) && last_data_d;
            if_done_q <= (state_d == DONE) && !last_data_d;
            if ((state_q == DPUSH) && phase_end) begin
                dp_rdata_q <= d_bus;
            end
            if ((state_q == IPUSH) && phase_end) begin
                if_rdata_q <= d_bus;
            end
        end
    end

    assign d_bus    = d_write_q ? wdata_q : 'z;
    assign d_read   = d_read_q;
    assign d_write  = d_write_q;
    assign d_push   = d_push_q;
    assign i_read   = i_read_q;
    assign i_push   = i_push_q;
    assign d_addr   = d_addr_q;
    assign i_addr   = i_addr_q;
    assign if_done  = if_done_q;
    assign dp_done  = dp_done_q;
    assign if_rdata = if_rdata_q;
    assign dp_rdata = dp_rdata_q;

endmodule

// File: tb/tb_mem_sequencer.sv
// Bench for mem_sequencer: one instance with STROBE_CYCLES=2 and one with
// STROBE_CYCLES=1, each attached to a small shared memory model.
module tb_mem_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic        is_fetch;
        logic        chk_data;
        logic [15:0] data;
    } exp_t;

    exp_t sb2[$];
    exp_t sb1[$];
    logic [15:0] mem [0:255];

    // STROBE_CYCLES = 2 instance
    logic        rst2_n, if_req2, if_done2, dp_req2, dp_we2, dp_done2;
    logic [15:0] if_addr2, if_rdata2, dp_addr2, dp_wdata2, dp_rdata2, d_addr2, i_addr2;
    logic        d_read2, d_write2, d_push2, i_read2, i_push2;
    wire  [15:0] d_bus2;

    // STROBE_CYCLES = 1 instance
    logic        rst1_n, if_req1, if_done1, dp_req1, dp_we1, dp_done1;
    logic [15:0] if_addr1, if_rdata1, dp_addr1, dp_wdata1, dp_rdata1, d_addr1, i_addr1;
    logic        d_read1, d_write1, d_push1, i_read1, i_push1;
    wire  [15:0] d_bus1;

    mem_sequencer #(.STROBE_CYCLES(2)) dut2 (
        .clk(clk), .rst_n(rst2_n),
        .if_req(if_req2), .if_addr(if_addr2), .if_done(if_done2), .if_rdata(if_rdata2),
        .dp_req(dp_req2), .dp_we(dp_we2), .dp_addr(dp_addr2), .dp_wdata(dp_wdata2),
        .dp_done(dp_done2), .dp_rdata(dp_rdata2),
        .d_read(d_read2), .d_write(d_write2), .d_push(d_push2),
        .i_read(i_read2), .i_push(i_push2),
        .d_addr(d_addr2), .i_addr(i_addr2), .d_bus(d_bus2)
    );

    mem_sequencer #(.STROBE_CYCLES(1)) dut1 (
        .clk(clk), .rst_n(rst1_n),
        .if_req(if_req1), .if_addr(if_addr1), .if_done(if_done1), .if_rdata(if_rdata1),
        .dp_req(dp_req1), .dp_we(dp_we1), .dp_addr(dp_addr1), .dp_wdata(dp_wdata1),
        .dp_done(dp_done1), .dp_rdata(dp_rdata1),
        .d_read(d_read1), .d_write(d_write1), .d_push(d_push1),
        .i_read(i_read1), .i_push(i_push1),
        .d_addr(d_addr1), .i_addr(i_addr1), .d_bus(d_bus1)
    );

    // Undriven bus floats to all ones so a stray drive is visible
    pullup (d_bus2);
    pullup (d_bus1);

    // Memory model: returns the addressed word during push phases
    assign d_bus2 = d_push2 ? mem[d_addr2[7:0]] : (i_push2 ? mem[i_addr2[7:0]] : 'z);
    assign d_bus1 = d_push1 ? mem[d_addr1[7:0]] : (i_push1 ? mem[i_addr1[7:0]] : 'z);

    // Memory model: store writes mid-cycle when the bus is stable
    always @(negedge clk) begin
        if (d_write2) mem[d_addr2[7:0]] = d_bus2;
        if (d_write1) mem[d_addr1[7:0]] = d_bus1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor for the S=2 instance: strobe exclusivity and completion scoreboard
    initial forever begin
        exp_t e2;
        @(negedge clk);
        chk("one_strobe2", 32'($countones({d_read2, d_write2, d_push2, i_read2, i_push2}) <= 1), 32'd1);
        if (dp_done2 || if_done2) begin
            if (sb2.size() == 0) begin
                chk("unexpected_done2", 32'({dp_done2, if_done2}), 32'd0);
            end else begin
                e2 = sb2.pop_front();
                chk("grant_order2", 32'(if_done2), 32'(e2.is_fetch));
                chk("dual_done2", 32'(dp_done2 & if_done2), 32'd0);
                if (e2.chk_data)
                    chk("rdata2", 32'(e2.is_fetch ? if_rdata2 : dp_rdata2), 32'(e2.data));
            end
        end
    end

    // Monitor for the S=1 instance
    initial forever begin
        exp_t e1;
        @(negedge clk);
        chk("one_strobe1", 32'($countones({d_read1, d_write1, d_push1, i_read1, i_push1}) <= 1), 32'd1);
        if (dp_done1 || if_done1) begin
            if (sb1.size() == 0) begin
                chk("unexpected_done1", 32'({dp_done1, if_done1}), 32'd0);
            end else begin
                e1 = sb1.pop_front();
                chk("grant_order1", 32'(if_done1), 32'(e1.is_fetch));
                chk("dual_done1", 32'(dp_done1 & if_done1), 32'd0);
                if (e1.chk_data)
                    chk("rdata1", 32'(e1.is_fetch ? if_rdata1 : dp_rdata1), 32'(e1.data));
            end
        end
    end

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    task automatic write2(input logic [15:0] a, input logic [15:0] d);
        @(posedge clk); #1;
        dp_req2 = 1'b1; dp_we2 = 1'b1; dp_addr2 = a; dp_wdata2 = d;
        sb2.push_back('{is_fetch: 1'b0, chk_data: 1'b0, data: 16'h0});
        @(negedge clk);
        chk("wr2_c0_write", 32'(d_write2), 32'd0);
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            if (c == 1) begin
                // Inputs changing after grant must not affect the transaction
                dp_addr2 = ~a; dp_wdata2 = ~d;
            end
            if (c <= 2) begin
                chk("wr2_write", 32'(d_write2), 32'd1);
                chk("wr2_bus", 32'(d_bus2), 32'(d));
                chk("wr2_addr", 32'(d_addr2), 32'(a));
                chk("wr2_done_early", 32'(dp_done2), 32'd0);
            end else begin
                chk("wr2_done", 32'(dp_done2), 32'd1);
                chk("wr2_write_off", 32'(d_write2), 32'd0);
                chk("wr2_bus_z", 32'(d_bus2), 32'hFFFF);
                dp_req2 = 1'b0;
            end
        end
    endtask

    task automatic read2(input logic [15:0] a, input logic [15:0] d, input bit abort);
        @(posedge clk); #1;
        dp_req2 = 1'b1; dp_we2 = 1'b0; dp_addr2 = a;
        sb2.push_back('{is_fetch: 1'b0, chk_data: 1'b1, data: d});
        @(negedge clk);
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            if (c <= 2) begin
                chk("rd2_read", 32'({d_read2, d_push2}), 32'b10);
            end else if (c <= 4) begin
                chk("rd2_push", 32'({d_read2, d_push2}), 32'b01);
                chk("rd2_addr", 32'(d_addr2), 32'(a));
                if (abort && c == 4) begin
                    rst2_n = 1'b0;
                    #1;
                    chk("rst2_async_strobes", 32'({d_read2, d_write2, d_push2, i_read2, i_push2}), 32'd0);
                    chk("rst2_async_addr", 32'(d_addr2), 32'd0);
                    chk("rst2_async_rdata", 32'(dp_rdata2), 32'd0);
                    sb2.delete();
                    dp_req2 = 1'b0;
                    repeat (2) @(posedge clk);
                    #1 rst2_n = 1'b1;
                    for (int k = 0; k < 8; k++) begin
                        @(negedge clk);
                        chk("rst2_no_done", 32'({dp_done2, if_done2}), 32'd0);
                    end
                    return;
                end
            end else begin
                chk("rd2_done", 32'(dp_done2), 32'd1);
                chk("rd2_rdata", 32'(dp_rdata2), 32'(d));
                chk("rd2_bus_z", 32'(d_bus2), 32'hFFFF);
                dp_req2 = 1'b0;
            end
        end
    endtask

    initial begin
        int n;
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        mem[3] = 16'hBEEF;
        rst2_n = 1'b0; rst1_n = 1'b0;
        if_req2 = 1'b0; if_addr2 = '0; dp_req2 = 1'b0; dp_we2 = 1'b0; dp_addr2 = '0; dp_wdata2 = '0;
        if_req1 = 1'b0; if_addr1 = '0; dp_req1 = 1'b0; dp_we1 = 1'b0; dp_addr1 = '0; dp_wdata1 = '0;
        repeat (2) @(posedge clk);
        #1 rst2_n = 1'b1;

        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("rst_strobes", 32'({d_read2, d_write2, d_push2, i_read2, i_push2}), 32'd0);
            chk("rst_done", 32'({dp_done2, if_done2}), 32'd0);
            chk("rst_addr", 32'({d_addr2, i_addr2}), 32'd0);
            chk("rst_bus_z", 32'(d_bus2), 32'hFFFF);
        end

        write2(16'd289, 16'd47);
        read2(16'd289, 16'd47, 1'b0);
        read2(16'd289, 16'd47, 1'b1);
        write2(16'd7, 16'd5);
        chk("mem_after_write", 32'(mem[7]), 32'd5);

        // Both requesters held from reset: data, fetch, data, fetch
        @(negedge clk);
        rst2_n = 1'b0;
        sb2.delete();
        dp_req2 = 1'b1; dp_we2 = 1'b0; dp_addr2 = 16'd289;
        if_req2 = 1'b1; if_addr2 = 16'd3;
        for (int k = 0; k < 2; k++) begin
            sb2.push_back('{is_fetch: 1'b0, chk_data: 1'b1, data: 16'd47});
            sb2.push_back('{is_fetch: 1'b1, chk_data: 1'b1, data: 16'hBEEF});
        end
        @(posedge clk); #1 rst2_n = 1'b1;
        n = 0;
        for (int c = 0; c < 60 && n < 4; c++) begin
            @(negedge clk);
            if (dp_done2 || if_done2) n++;
            if (n == 4) begin
                dp_req2 = 1'b0; if_req2 = 1'b0;
            end
        end
        chk("rr_done_count", 32'(n), 32'd4);
        repeat (8) @(negedge clk);
        chk("rr_sb_empty", 32'(sb2.size()), 32'd0);

        // STROBE_CYCLES = 1 instance
        #1 rst1_n = 1'b1;
        @(posedge clk); #1;
        dp_req1 = 1'b1; dp_we1 = 1'b1; dp_addr1 = 16'd10; dp_wdata1 = 16'h1234;
        sb1.push_back('{is_fetch: 1'b0, chk_data: 1'b0, data: 16'h0});
        @(negedge clk);
        @(negedge clk);
        chk("s1_wr_write", 32'({d_write1, d_bus1}), 32'h11234);
        chk("s1_wr_done_early", 32'(dp_done1), 32'd0);
        @(negedge clk);
        chk("s1_wr_done", 32'({dp_done1, d_write1}), 32'b10);
        dp_req1 = 1'b0;

        @(posedge clk); #1;
        if_req1 = 1'b1; if_addr1 = 16'd3;
        sb1.push_back('{is_fetch: 1'b1, chk_data: 1'b1, data: 16'hBEEF});
        @(negedge clk);
        @(negedge clk);
        chk("s1_f_read", 32'({i_read1, i_push1}), 32'b10);
        chk("s1_f_addr", 32'(i_addr1), 32'd3);
        @(negedge clk);
        chk("s1_f_push", 32'({i_read1, i_push1}), 32'b01);
        @(negedge clk);
        chk("s1_f_done", 32'(if_done1), 32'd1);
        chk("s1_f_rdata", 32'(if_rdata1), 32'hBEEF);
        if_req1 = 1'b0;
        repeat (4) @(negedge clk);
        chk("s1_sb_empty", 32'(sb1.size()), 32'd0);
        chk("s2_sb_empty", 32'(sb2.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_sequencer.md
# mem_sequencer

Sequencer and arbiter for the shared 16-bit memory. It accepts transactions from two requesters: the instruction-fetch port and the data port. It grants one at a time and drives the memory strobe protocol (`d_read`/`d_write`/`d_push`, `i_read`/`i_push`) with correct phase lengths. Read data comes back on the single bidirectional `d_bus`, so the block also owns the bus drive enable and turnaround.

## Interface
- `STROBE_CYCLES`, default 2: cycles each memory strobe phase is held. Legal range 1–4.
- `clk` in 1: system clock. All state changes on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `if_req` in 1: fetch request. Held high until `if_done`.
- `if_addr` in 16: fetch address. Sampled at grant.
- `if_done` out 1: one-cycle pulse. `if_rdata` is valid in this cycle.
- `if_rdata` out 16: fetched word. Holds until the next fetch completes.
- `dp_req` in 1: data request. Held high until `dp_done`.
- `dp_we` in 1: 1 = write, 0 = read. Sampled at grant.
- `dp_addr` in 16: data address. Sampled at grant.
- `dp_wdata` in 16: write data. Sampled at grant.
- `dp_done` out 1: one-cycle completion pulse, for both reads and writes.
- `dp_rdata` out 16: read data. Holds until the next data read completes.
- `d_read`, `d_write`, `d_push`, `i_read`, `i_push` out 1 each: memory strobes. Registered.
- `d_addr`, `i_addr` out 16 each: memory addresses. Registered and held for the whole transaction.
- `d_bus` inout 16: driven only while `d_write`=1; high-Z otherwise.

## Operation
- States:
  - IDLE
  - DWR (write)
  - DRD (data read)
  - DPUSH (data push)
  - IRD (instruction read)
  - IPUSH (instruction push)
  - DONE
- A phase counter counts `STROBE_CYCLES` cycles in each strobe state.
- IDLE:
  - Only `dp_req`=1: grant data. Capture `dp_we`/`dp_addr`/`dp_wdata`. Go to DWR if `dp_we`, else DRD.
  - Only `if_req`=1: grant fetch. Capture `if_addr`. Go to IRD.
  - Both requests: grant the requester not granted last, tracked by `last_grant`. Reset value of `last_grant` = fetch, so data wins the first tie.
  - Neither request: stay in IDLE.
- Strobes and addresses per state:
  - DWR: `d_write`=1, `d_addr` = captured address, `d_bus` = captured wdata. Lasts `STROBE_CYCLES`, then DONE.
  - DRD: `d_read`=1 for `STROBE_CYCLES`, then DPUSH.
  - DPUSH: `d_push`=1 for `STROBE_CYCLES`. On the last push cycle, `d_bus` is sampled into `dp_rdata`. Then DONE.
  - IRD: `i_read`=1 for `STROBE_CYCLES`, with `i_addr` = captured address. Then IPUSH.
  - IPUSH: `i_push`=1 for `STROBE_CYCLES`. The memory returns the word on `d_bus`; it is sampled into `if_rdata` on the last cycle. Then DONE.
- DONE:
  - Pulse the granted requester's done signal for one cycle. All strobes 0. Bus high-Z.
  - No new grant is made in DONE. Next state is IDLE.
- A `req` that is still high in the IDLE cycle after DONE is treated as a new transaction (back-to-back allowed).
- Dropping `req` mid-transaction is ignored: the transaction completes and done is still pulsed.
- At most one strobe is high in any cycle. `d_write` is never high in the same cycle as `d_push` or `i_push`.
- Reset, including mid-transaction:
  - State = IDLE, all strobes 0, done outputs 0, `d_bus` high-Z.
  - Addresses and rdata registers = 0. `last_grant` = fetch.
  - The in-flight transaction is dropped and no done is issued for it.

## Timing
- Cycle 0 is the IDLE cycle in which the request is sampled. S = `STROBE_CYCLES`.
- Write:
  - Strobe cycles 1..S.
  - Done in cycle S+1.
  - Earliest next grant in cycle S+2.
- Read or fetch:
  - Read strobe cycles 1..S; push strobe cycles S+1..2S.
  - Data captured at the clock edge that ends cycle 2S.
  - Done, with rdata valid, in cycle 2S+1.
- With S=2: write done at cycle 3, read done at cycle 5.
- Bus turnaround: at least one non-driving cycle (DONE plus IDLE) between the arbiter driving `d_bus` and any push cycle.
- Strobes, addresses and bus enable come from registers; no combinational path from `req` to memory outputs.

## Test plan
- Reset release with no requests: all strobes 0, `if_done`=`dp_done`=0, `d_addr`=`i_addr`=0, `d_bus` high-Z for at least 10 cycles.
- S=2 data write, `dp_addr`=289, `dp_wdata`=47:
  - `d_write`=1 in cycles 1–2 with `d_bus`=47 and `d_addr`=289.
  - `dp_done` pulses in cycle 3. `d_bus` is high-Z in cycle 3.
- S=2 data read of 289 against a memory model holding 47:
  - `d_read` in cycles 1–2, `d_push` in cycles 3–4.
  - `dp_done` in cycle 5 with `dp_rdata`=47.
- Round-robin: `if_req` and `dp_req` both held continuously from reset.
  - Grants alternate data, fetch, data, fetch.
  - No cycle has two strobes high; each done pulses exactly once per transaction.
- `rst_n` asserted in the second `d_push` cycle of a read:
  - Strobes drop immediately, without waiting for a clock edge.
  - No `dp_done` is issued after release.
  - A following write of 5 to address 7 completes normally.
- `STROBE_CYCLES`=1:
  - Write done in cycle 2.
  - Fetch of address 3 (model returns 16'hBEEF): `i_read` in cycle 1, `i_push` in cycle 2, `if_done` in cycle 3 with `if_rdata`=16'hBEEF.
